// File: rtl/sd_clk_div_if.sv
// SD clock generator control/status bundle: divider load, run/burst control,
// and the generated clock with its edge strobes.
interface sd_clk_div_if #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned BURST_W = 8
);
  logic [DIV_W-1:0]   div_i;
  logic               div_load;
  logic               div_ack;
  logic               clk_en;
  logic               burst_start;
  logic [BURST_W-1:0] burst_n;
  logic               burst_busy;
  logic               sd_clk;
  logic               rise_stb;
  logic               fall_stb;
  logic               running;

  // Controller side: programs the divider and requests clocks.
  modport master (
    output div_i, div_load, clk_en, burst_start, burst_n,
    input  div_ack, burst_busy, sd_clk, rise_stb, fall_stb, running
  );

  // Generator side.
  modport slave (
    input  div_i, div_load, clk_en, burst_start, burst_n,
    output div_ack, burst_busy, sd_clk, rise_stb, fall_stb, running
  );
endinterface

// File: rtl/sd_clk_div.sv
// Programmable SD card clock generator. Half period = div_q+1 clk cycles.
// Divider changes take effect only at a falling edge (or while stopped), so
// no phase ever mixes old and new lengths. Starts/stops happen in the low
// phase; a counted burst supplies a fixed number of rising edges.
module sd_clk_div #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 62,
  parameter int unsigned BURST_W     = 8
) (
  input  logic        clk,
  input  logic        res,
  sd_clk_div_if.slave bus
);

  typedef enum logic [1:0] {
    STOPPED,
    RUN_LOW,
    RUN_HIGH
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   pending;
  logic               pend;
  logic [DIV_W-1:0]   cnt;
  logic [BURST_W-1:0] bcnt;
  logic               busy;
  logic               sd_clk_q;
  logic               rise_q;
  logic               fall_q;
  logic               ack_q;

  logic run;
  logic hit;
  logic fall_ev;
  logic apply;
  logic start;
  logic burst_clr;
  logic run_after;

  // Decode of phase boundaries, divider apply and burst bookkeeping.
  always_comb begin
    run       = bus.clk_en | busy;
    hit       = (cnt == div_q);
    fall_ev   = (state == RUN_HIGH) && hit;
    apply     = pend && (fall_ev || (state == STOPPED));
    start     = bus.burst_start && (bus.burst_n != '0) && !busy;
    burst_clr = fall_ev && busy && (bcnt == '0);
    // Whether to keep going after a fall, taking this cycle's burst update into account.
    run_after = bus.clk_en | start | (busy & ~burst_clr);
  end

  // Clock FSM, divider pending/apply and burst counter.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= STOPPED;
      div_q    <= DIV_W'(DEFAULT_DIV);
      pending  <= '0;
      pend     <= 1'b0;
      cnt      <= '0;
      bcnt     <= '0;
      busy     <= 1'b0;
      sd_clk_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      ack_q  <= apply;

      // A load coinciding with an apply replaces the old pending value.
      if (apply) begin
        div_q <= bus.div_load ? bus.div_i : pending;
        pend  <= 1'b0;
      end else if (bus.div_load) begin
        pending <= bus.div_i;
        pend    <= 1'b1;
      end

      if (start) begin
        busy <= 1'b1;
        bcnt <= bus.burst_n;
      end else if (burst_clr) begin
        busy <= 1'b0;
      end

      case (state)
        STOPPED: begin
          cnt      <= '0;
          sd_clk_q <= 1'b0;
          if (run) state <= RUN_LOW;
        end
        RUN_LOW: begin
          if (!run) begin
            cnt   <= '0;
            state <= STOPPED;
          end else if (hit) begin
            cnt      <= '0;
            sd_clk_q <= 1'b1;
            rise_q   <= 1'b1;
            state    <= RUN_HIGH;
            if (busy) bcnt <= bcnt - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN_HIGH: begin
          if (hit) begin
            cnt      <= '0;
            sd_clk_q <= 1'b0;
            fall_q   <= 1'b1;
            state    <= run_after ? RUN_LOW : STOPPED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt      <= '0;
          sd_clk_q <= 1'b0;
          state    <= STOPPED;
        end
      endcase
    end
  end

  assign bus.sd_clk     = sd_clk_q;
  assign bus.rise_stb   = rise_q;
  assign bus.fall_stb   = fall_q;
  assign bus.div_ack    = ack_q;
  assign bus.burst_busy = busy;
  assign bus.running    = (state != STOPPED);

endmodule

// File: tb/tb_sd_clk_div.sv
// Testbench for sd_clk_div: directed scenarios plus random traffic, every
// cycle compared against a phase-countdown reference model.
module tb_sd_clk_div;

  localparam int DIV_W       = 8;
  localparam int BURST_W     = 8;
  localparam int DEFAULT_DIV = 62;

  logic clk = 1'b0;
  logic res;

  always #5 clk = ~clk;

  sd_clk_div_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  sd_clk_div #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .BURST_W    (BURST_W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the clock is either off, or in a low/high phase with a
  // number of cycles left; a phase always lasts div+1 cycles.
  bit m_on;
  bit m_level;
  int m_left;
  int m_div;
  bit m_pend;
  int m_pval;
  bit m_busy;
  int m_rises;
  bit e_rise;
  bit e_fall;
  bit e_ack;

  int rise_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on    = 1'b0;
    m_level = 1'b0;
    m_left  = 0;
    m_div   = DEFAULT_DIV;
    m_pend  = 1'b0;
    m_pval  = 0;
    m_busy  = 1'b0;
    m_rises = 0;
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    e_ack   = 1'b0;
  endtask

  task automatic model_step();
    bit run, start, phase_end, rising, falling, apply, finish, busy_n;
    int new_div;
    run       = bus.clk_en || m_busy;
    start     = bus.burst_start && (bus.burst_n != 0) && !m_busy;
    phase_end = m_on && (m_left == 1);
    rising    = phase_end && !m_level && run;
    falling   = phase_end && m_level;
    apply     = m_pend && (falling || !m_on);
    finish    = falling && m_busy && (m_rises == 0);
    new_div   = apply ? (bus.div_load ? int'(bus.div_i) : m_pval) : m_div;
    if (apply) m_pend = 1'b0;
    else if (bus.div_load) begin
      m_pend = 1'b1;
      m_pval = int'(bus.div_i);
    end
    busy_n = start ? 1'b1 : (finish ? 1'b0 : m_busy);
    if (start) m_rises = int'(bus.burst_n);
    else if (rising && m_busy) m_rises--;
    if (!m_on) begin
      if (run) begin
        m_on = 1'b1; m_level = 1'b0; m_left = new_div + 1;
      end
    end else if (!m_level) begin
      if (!run) begin
        m_on = 1'b0;
      end else if (rising) begin
        m_level = 1'b1; m_left = new_div + 1;
      end else begin
        m_left--;
      end
    end else begin
      if (falling) begin
        m_level = 1'b0;
        m_on    = bus.clk_en || busy_n;
        m_left  = new_div + 1;
      end else begin
        m_left--;
      end
    end
    m_div  = new_div;
    m_busy = busy_n;
    e_rise = rising;
    e_fall = falling;
    e_ack  = apply;
  endtask

  task automatic compare();
    check("sd_clk",     bus.sd_clk,     m_on && m_level);
    check("rise_stb",   bus.rise_stb,   e_rise);
    check("fall_stb",   bus.fall_stb,   e_fall);
    check("div_ack",    bus.div_ack,    e_ack);
    check("burst_busy", bus.burst_busy, m_busy);
    check("running",    bus.running,    m_on);
  endtask

  task automatic tick();
    if (res) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare();
    if (bus.rise_stb) rise_cnt++;
    bus.div_load    = 1'b0;
    bus.burst_start = 1'b0;
  endtask

  task automatic load_div(input int v);
    bus.div_i    = DIV_W'(v);
    bus.div_load = 1'b1;
    tick();
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.rise_stb && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, bus.rise_stb, 1'b1);
  endtask

  initial begin
    res             = 1'b1;
    bus.div_i       = '0;
    bus.div_load    = 1'b0;
    bus.clk_en      = 1'b0;
    bus.burst_start = 1'b0;
    bus.burst_n     = '0;
    rise_cnt        = 0;
    model_reset();
    #1;
    compare();
    repeat (3) tick();
    res = 1'b0;
    tick();

    // Free running at the default divider.
    bus.clk_en = 1'b1;
    repeat (400) tick();

    // Load divider 0 in the middle of a high phase.
    wait_rise("s2_rise", 300);
    repeat (10) tick();
    load_div(0);
    repeat (100) tick();

    // Divider 4, then drop clk_en two cycles into a high phase.
    load_div(4);
    repeat (3) tick();
    wait_rise("s3_rise", 50);
    tick();
    bus.clk_en = 1'b0;
    repeat (30) tick();

    // Zero-length burst is ignored; then a 74-edge init burst at 62.
    bus.burst_n     = '0;
    bus.burst_start = 1'b1;
    tick();
    repeat (5) tick();
    load_div(62);
    repeat (3) tick();
    bus.burst_n     = BURST_W'(74);
    bus.burst_start = 1'b1;
    rise_cnt        = 0;
    tick();
    repeat (74 * 126 + 200) tick();
    check("burst_rises", rise_cnt, 74);
    check("burst_stopped", bus.running, 1'b0);

    // Two loads before the next boundary: last wins, single ack.
    bus.clk_en = 1'b1;
    repeat (20) tick();
    load_div(3);
    repeat (4) tick();
    load_div(7);
    repeat (300) tick();

    // Reset in the middle of a burst while sd_clk is high.
    bus.clk_en = 1'b0;
    repeat (40) tick();
    bus.burst_n     = BURST_W'(20);
    bus.burst_start = 1'b1;
    tick();
    wait_rise("s6_rise", 100);
    tick();
    #2;
    res = 1'b1;
    #1;
    check("rst_sd_clk", bus.sd_clk, 1'b0);
    check("rst_busy",   bus.burst_busy, 1'b0);
    check("rst_rise",   bus.rise_stb, 1'b0);
    check("rst_fall",   bus.fall_stb, 1'b0);
    check("rst_run",    bus.running, 1'b0);
    repeat (3) tick();
    res = 1'b0;
    tick();
    bus.clk_en = 1'b1;
    repeat (300) tick();

    // Random traffic with small dividers.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.clk_en = ~bus.clk_en;
      if ($urandom_range(0, 39) == 0) begin
        bus.div_i    = DIV_W'($urandom_range(0, 5));
        bus.div_load = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) begin
        bus.burst_n     = BURST_W'($urandom_range(0, 6));
        bus.burst_start = 1'b1;
      end
      if ($urandom_range(0, 1499) == 0) res = 1'b1;
      tick();
      res = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_clk_div.md
Name: sd_clk_div

Overview:
- Programmable SD card clock generator. Successor to the fixed two-speed SD clock generator.
- Produces sd_clk from the system clock with a runtime-loadable divider.
- Divider changes are glitch-free, the clock stops and starts cleanly in the low phase, and a counted burst mode supplies the ≥74 init clocks.
- Emits single-cycle edge strobes so the command/data FSMs sample and drive in lockstep with sd_clk.

Parameters:
- DIV_W, 8, width of the half-period divider value.
- DEFAULT_DIV, 62, divider after reset. Half period = DEFAULT_DIV+1 clk cycles, i.e. 396.8 kHz from 50 MHz.
- BURST_W, 8, width of the burst edge count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- res  in  1  asynchronous, active-high reset.
- div_i  in  DIV_W  new half-period value; half period = div_i+1 cycles; 0 gives clk/2.
- div_load  in  1  one-cycle pulse; capture div_i as the pending divider.
- div_ack  out  1  one-cycle pulse when the pending divider becomes active.
- clk_en  in  1  level; 1 = run sd_clk continuously.
- burst_start  in  1  one-cycle pulse; start a counted burst.
- burst_n  in  BURST_W  number of rising edges in the burst.
- burst_busy  out  1  burst in progress.
- sd_clk  out  1  SD card clock, registered.
- rise_stb  out  1  high in the first clk cycle of each sd_clk high phase.
- fall_stb  out  1  high in the first clk cycle of each sd_clk low phase.
- running  out  1  generator not in STOPPED.

Behaviour:
- Reset values (async, immediate):
  - sd_clk=0, rise_stb=0, fall_stb=0, div_ack=0, burst_busy=0, running=0.
  - Active divider div_q=DEFAULT_DIV, no divider pending, cnt=0, state STOPPED.
- run = clk_en | burst_busy.
- State machine, states STOPPED / RUN_LOW / RUN_HIGH:
  - STOPPED: sd_clk=0, cnt held 0. If run=1, go to RUN_LOW next cycle, counting from 0.
  - RUN_LOW: cnt increments each cycle. When cnt==div_q: sd_clk<=1, cnt<=0, rise_stb<=1, go to RUN_HIGH.
  - RUN_HIGH: cnt increments. When cnt==div_q: sd_clk<=0, cnt<=0, fall_stb<=1. Go to RUN_LOW if run is still 1 after the burst update this cycle, else STOPPED.
- Stop rules:
  - Stopping happens only at the end of a high phase, or from RUN_LOW.
  - If run=0 in RUN_LOW: go to STOPPED next cycle, sd_clk stays 0, no strobe.
  - A started high phase always completes its full div_q+1 cycles; no runt pulses.
- First rising edge after leaving STOPPED: div_q+1 cycles after entering RUN_LOW.
- Divider update:
  - div_load latches div_i into pending and sets pend. A later load before apply overwrites it; last wins, one ack.
  - Pending is applied at the falling-edge cycle (RUN_HIGH, cnt==div_q): div_q<=pending, pend<=0, div_ack=1 the next cycle.
  - In STOPPED, pending is applied on the cycle after the load, with ack.
  - A div_load in the same cycle as an apply is applied in place of the old pending.
  - High/low phase lengths never mix old and new values.
- Burst:
  - burst_start with burst_n≠0 and burst_busy=0: load bcnt=burst_n, set burst_busy.
  - Each rise_stb decrements bcnt.
  - On the fall completing the rise where bcnt reached 0, burst_busy<=0 in that same cycle.
  - burst_start is ignored while busy or when burst_n=0.
  - clk_en=1 during a burst keeps the clock running afterwards; the burst still counts and clears.
- Reset mid-operation aborts everything; sd_clk drops low asynchronously.
- Strobes are registered and coincide with the sd_clk level change. They are never both high.

Test Plan:
- Reset, clk_en=1, no load -> first rise_stb 63 cycles after clk_en; sd_clk period 126 cycles; rise/fall alternate every 63.
- Load div_i=0 mid-high-phase -> current high phase lasts 63 cycles; div_ack 1 cycle after the fall; then sd_clk toggles every cycle (25 MHz); no phase <1 or mixed length.
- clk_en 1->0 two cycles into a high phase (div_q=4) -> high lasts a full 5 cycles, fall_stb, then STOPPED; running=0; sd_clk held 0; no further strobes.
- clk_en=0, burst_n=74, div_q=62 -> exactly 74 rise_stb; burst_busy falls with the 74th fall_stb; then STOPPED.
- Two div_load pulses (3, then 7) before a boundary -> single div_ack; phases become 8 cycles.
- Assert res mid-burst with sd_clk high -> sd_clk, burst_busy, strobes are 0 immediately; div_q=62 after release.
